// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan decoder.
// Codes, active-low segment patterns (g..a) and tracker states.
package seg7_pkg;

  localparam logic [4:0] CODE_BLANK   = 5'h10;
  localparam logic [4:0] CODE_INVALID = 5'h1F;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_HELD
  } trk_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low 7-bit segment pattern to 5-bit code.
// Ports: pat (g..a, active-low) in, code out (blank 10h, unknown 1Fh).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [4:0] code
);

  always_comb begin
    code = CODE_INVALID;
    unique case (pat)
      SEG_0:     code = 5'h0;
      SEG_1:     code = 5'h1;
      SEG_2:     code = 5'h2;
      SEG_3:     code = 5'h3;
      SEG_4:     code = 5'h4;
      SEG_5:     code = 5'h5;
      SEG_6:     code = 5'h6;
      SEG_7:     code = 5'h7;
      SEG_8:     code = 5'h8;
      SEG_9:     code = 5'h9;
      SEG_A:     code = 5'hA;
      SEG_B:     code = 5'hB;
      SEG_C:     code = 5'hC;
      SEG_D:     code = 5'hD;
      SEG_E:     code = 5'hE;
      SEG_F:     code = 5'hF;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed active-low 7-seg bus and
// publishes decoded digits/dp as atomic frames. Ports: clk, rst_n,
// seg_n, an_n in; digits, dp, frame_valid, err_pattern, err_anode out.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [5*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    frame_valid,
  output logic                    err_pattern,
  output logic                    err_anode
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int LW = $clog2(NUM_DIGITS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [7:0]              seg_m, seg_s, held_seg;
  logic [NUM_DIGITS-1:0]   an_m, an_s, held_an;
  logic [LW-1:0]           low_cnt;
  logic [IW-1:0]           idx;
  logic                    one_hot, same;
  trk_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    load, capture;
  logic [4:0]              code;
  logic [5*NUM_DIGITS-1:0] sh_code, sh_code_n;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_n;
  logic [NUM_DIGITS-1:0]   mask, mask_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1;
      seg_s <= '1;
      an_m  <= '1;
      an_s  <= '1;
    end else begin
      seg_m <= seg_n;
      seg_s <= seg_m;
      an_m  <= an_n;
      an_s  <= an_m;
    end
  end

  // Count low anodes; idx ends on the lowest active digit.
  always_comb begin
    low_cnt = '0;
    idx     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!an_s[i]) begin
        low_cnt = low_cnt + 1'b1;
        idx     = IW'(i);
      end
    end
  end

  assign one_hot   = (low_cnt == LW'(1));
  assign err_anode = (low_cnt > LW'(1));
  assign same      = (seg_s == held_seg) && (an_s == held_an);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_TRACK: begin
        if (same) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(STABLE_CYCLES - 1))
            state_d = ST_HELD;
        end else if (one_hot) begin
          cnt_d = CW'(1);
          load  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_HELD: begin
        if (!same) begin
          if (one_hot) begin
            state_d = ST_TRACK;
            cnt_d   = CW'(1);
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        cnt_d = '0;
        if (one_hot) begin
          state_d = ST_TRACK;
          cnt_d   = CW'(1);
          load    = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    capture = (state_q == ST_TRACK) && same &&
              (cnt_q == CW'(STABLE_CYCLES - 1));
  end

  seg7_pattern_decode u_dec (
    .pat  (seg_s[6:0]),
    .code (code)
  );

  always_comb begin
    sh_code_n             = sh_code;
    sh_code_n[5*idx +: 5] = code;
    sh_dp_n               = sh_dp;
    sh_dp_n[idx]          = ~seg_s[7];
    mask_n                = mask;
    mask_n[idx]           = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_seg    <= '1;
      held_an     <= '1;
      sh_code     <= {NUM_DIGITS{CODE_BLANK}};
      sh_dp       <= '0;
      mask        <= '0;
      digits      <= {NUM_DIGITS{CODE_BLANK}};
      dp          <= '0;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      if (load) begin
        held_seg <= seg_s;
        held_an  <= an_s;
      end
      if (capture) begin
        sh_code     <= sh_code_n;
        sh_dp       <= sh_dp_n;
        err_pattern <= (code == CODE_INVALID);
        // Last missing digit completes the frame atomically.
        if (&mask_n) begin
          digits      <= sh_code_n;
          dp          <= sh_dp_n;
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask <= mask_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed checks for seg7_scan_decoder.
// Drives the scan bus and checks frames, errors and latency.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic [19:0] digits;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_anode;

  int npass = 0;
  int ntot  = 0;
  int fv_cnt = 0;
  int ep_cnt = 0;
  int ea_cnt = 0;

  localparam logic [19:0] BLANK4 = {4{5'h10}};

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .dp          (dp),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_anode   (err_anode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (err_pattern) ep_cnt++;
    if (err_anode)   ea_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    fv_cnt = 0;
    ep_cnt = 0;
    ea_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg_n = 8'hFF;
    an_n  = 4'hF;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clr_cnt();
  endtask

  task automatic scan(input int d, input logic [7:0] s, input int dw);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    tick(dw);
  endtask

  task automatic gap(input int n);
    an_n  = 4'hF;
    seg_n = 8'hFF;
    tick(n);
  endtask

  initial begin
    rst_n = 1'b0;
    seg_n = 8'hFF;
    an_n  = 4'hF;
    tick(2);

    // reset state
    chk("rst_digits", 32'(digits), 32'(BLANK4));
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_ep", 32'(err_pattern), 32'h0);
    chk("rst_ea", 32'(err_anode), 32'h0);

    // capture latency: invalid pattern from reset, edge 6
    seg_n = 8'hAA;
    an_n  = 4'b1110;
    rst_n = 1'b1;
    clr_cnt();
    tick(5);
    chk("lat_edge5", 32'(err_pattern), 32'h0);
    tick(1);
    chk("lat_edge6", 32'(err_pattern), 32'h1);
    tick(1);
    chk("lat_edge7", 32'(err_pattern), 32'h0);

    // dwell 3 never captures, dwell 4 does
    scan(1, 8'hAA, 3);
    gap(8);
    chk("dwell3_ep", 32'(ep_cnt), 32'd1);
    scan(1, 8'hAA, 4);
    gap(8);
    chk("dwell4_ep", 32'(ep_cnt), 32'd2);
    chk("dwell_fv", 32'(fv_cnt), 32'd0);

    // basic scan 0..3
    do_reset();
    scan(0, 8'hC0, 20);
    scan(1, 8'hF9, 20);
    scan(2, 8'hA4, 20);
    chk("scan_partial_fv", 32'(fv_cnt), 32'd0);
    chk("scan_partial_dig", 32'(digits), 32'(BLANK4));
    scan(3, 8'hB0, 20);
    gap(4);
    chk("scan_fv", 32'(fv_cnt), 32'd1);
    chk("scan_digits", 32'(digits),
        32'({5'h3, 5'h2, 5'h1, 5'h0}));
    chk("scan_dp", 32'(dp), 32'h0);
    chk("scan_ep", 32'(ep_cnt), 32'd0);
    chk("scan_ea", 32'(ea_cnt), 32'd0);

    // B pattern, invalid pattern with dp lit
    do_reset();
    scan(0, 8'hC0, 20);
    scan(1, 8'h83, 20);
    scan(2, 8'h0A, 20);
    chk("pat_ep", 32'(ep_cnt), 32'd1);
    scan(3, 8'hB0, 20);
    gap(4);
    chk("pat_fv", 32'(fv_cnt), 32'd1);
    chk("pat_digits", 32'(digits),
        32'({5'h3, 5'h1F, 5'hB, 5'h0}));
    chk("pat_dp", 32'(dp), 32'h4);

    // multi-anode sample
    do_reset();
    scan(0, 8'hC0, 20);
    an_n  = 4'b0011;
    seg_n = 8'hC0;
    tick(5);
    chk("multi_ea_now", 32'(err_anode), 32'h1);
    tick(5);
    gap(6);
    chk("multi_ea_cnt", 32'(ea_cnt), 32'd10);
    chk("multi_ea_off", 32'(err_anode), 32'h0);
    scan(1, 8'hF9, 20);
    gap(4);
    chk("multi_mask_fv", 32'(fv_cnt), 32'd0);
    scan(2, 8'hA4, 20);
    scan(3, 8'hB0, 20);
    gap(4);
    chk("multi_fv", 32'(fv_cnt), 32'd1);
    chk("multi_digits", 32'(digits),
        32'({5'h3, 5'h2, 5'h1, 5'h0}));

    // rescan digit 0 before the rest
    do_reset();
    scan(0, 8'hC0, 20);
    scan(0, 8'h99, 20);
    chk("rescan_fv0", 32'(fv_cnt), 32'd0);
    scan(1, 8'hF9, 20);
    scan(2, 8'hA4, 20);
    scan(3, 8'hB0, 20);
    gap(4);
    chk("rescan_fv", 32'(fv_cnt), 32'd1);
    chk("rescan_digits", 32'(digits),
        32'({5'h3, 5'h2, 5'h1, 5'h4}));

    // reset mid frame
    scan(0, 8'h92, 20);
    scan(1, 8'h82, 20);
    scan(2, 8'hF8, 20);
    chk("mid_pre_digits", 32'(digits),
        32'({5'h3, 5'h2, 5'h1, 5'h4}));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", 32'(digits), 32'(BLANK4));
    chk("mid_rst_dp", 32'(dp), 32'h0);
    seg_n = 8'hFF;
    an_n  = 4'hF;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clr_cnt();
    scan(3, 8'hB0, 20);
    gap(4);
    chk("mid_d3_only_fv", 32'(fv_cnt), 32'd0);
    scan(0, 8'h92, 20);
    scan(1, 8'h82, 20);
    scan(2, 8'hF8, 20);
    gap(4);
    chk("mid_fv", 32'(fv_cnt), 32'd1);
    chk("mid_digits", 32'(digits),
        32'({5'h3, 5'h7, 5'h6, 5'h5}));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
